prpg_seq_ctrl: RTL and testbench
================================

PRPG_SEQ_CTRL -- requirements
Module: prpg_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, LFSR width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, run-length counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  job request; sampled only in IDLE.
REQ-006 SHALL have port tap  input  W-1  feedback tap mask; captured at start.
REQ-007 SHALL have port seed  input  W  initial pattern; captured at start.
REQ-008 SHALL have port run_len  input  CNT_W  number of LFSR steps; captured at start.
REQ-009 SHALL have port hold  input  1  stalls stepping while high.
REQ-010 SHALL have the following output ports:
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle job-complete pulse.
- pattern  output  W  current LFSR register.
- pattern_vld  output  1  high for one cycle after each committed step.
- step_cnt  output  CNT_W  steps committed in the current job.
- hd_avg  output  $clog2(W+1)  floor of mean per-step Hamming distance.
- err_lockup  output  1  seed was all-zero; valid while done is high.

Function
REQ-011 SHALL implement FSM states IDLE, LOAD, RUN, AVG, DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-012 SHALL, on start=1 in IDLE at edge t, capture tap, seed and run_len and enter LOAD; start in any other state SHALL be ignored.
REQ-013 SHALL, in LOAD, set pattern<=seed, step_cnt<=0 and the HD sum to 0, then transition as follows:
- to DONE if seed==0 (err_lockup<=1) or run_len==0;
- to RUN otherwise.
REQ-014 SHALL, in RUN with hold=0, step pattern P as follows:
- next[0]=P[W-1];
- next[i]=P[i-1]^(tap[W-1-i]&P[W-1]) for i=1..W-1;
- step_cnt increments and pattern_vld=1 on the following cycle.
REQ-015 SHALL, in RUN with hold=1, leave pattern, step_cnt and the HD sum unchanged, with pattern_vld=0.
REQ-016 SHALL add popcount(P^next) to an unsigned HD sum of width SUM_W=$clog2(W+1)+CNT_W on each committed step; the sum SHALL never wrap.
REQ-017 SHALL leave RUN after the step that makes step_cnt==run_len, entering AVG (macro defined) or DONE (macro undefined).
REQ-018 SHALL, in AVG, compute hd_avg=floor(HD sum / run_len) in exactly SUM_W cycles, then enter DONE.
REQ-019 SHALL hold done=1 only in DONE; hd_avg, pattern and step_cnt SHALL hold their values until the next LOAD.
REQ-020 SHALL set hd_avg=0 when run_len==0 or on lockup; no division SHALL be started in those cases.
REQ-021 SHALL take the following latency with no hold:
- done high in the cycle after edge t+2+run_len+SUM_W with the macro defined;
- done high in the cycle after edge t+2+run_len without the macro.

Reset
REQ-022 SHALL, while rst_n=0 at any time including mid-job, force the following values:
- state IDLE;
- busy, done, pattern_vld, err_lockup = 0;
- pattern, step_cnt, hd_avg, HD sum = 0;
- any in-progress division discarded.

Configuration
REQ-023 SHALL gate HD statistics with macro PRPG_HD_STATS_EN:
- defined: HD sum, AVG state and divider present;
- undefined: no HD logic, hd_avg tied 0, RUN goes directly to DONE.

Structure
REQ-024 SHALL place the following in shared package prpg_pkg: the state enum, the default W/CNT_W constants, and a SUM_W width function.
REQ-025 SHALL implement the division as sub-module prpg_hd_div, a serial restoring divider with start/done handshake and a latency of SUM_W cycles.

Verification
REQ-026 SHALL cover the following directed scenarios:
- tap=0, seed=8'h01, run_len=8 -> pattern returns to 8'h01 after 8 steps; hd_avg=2; 8 pattern_vld pulses; done in the cycle after edge t+22.
- seed=8'h00, run_len=5 -> err_lockup=1, step_cnt=0, hd_avg=0; done in the cycle after edge t+1.
- run_len=0, seed=8'h0F -> no steps, hd_avg=0, err_lockup=0; done in the cycle after edge t+1.
- tap=7'b0100101, seed=8'h0F, run_len=10, hold high 3 cycles mid-run -> pattern sequence matches the model; done 3 cycles later than the unheld run.
- start pulsed during RUN -> ignored; captured run_len unchanged; exactly one done pulse.
- rst_n low during AVG -> all outputs 0 asynchronously; a new start after release runs normally.

Source files
------------

// File: rtl/prpg_pkg.sv
// prpg_pkg -- shared definitions for the PRPG sequence controller.
//
// Contents:
//   state_e    : controller FSM state encoding
//   DEF_W      : default LFSR width
//   DEF_CNT_W  : default run-length counter width
//   sum_w()    : width of the Hamming-distance accumulator; wide enough that
//                W * (2**CNT_W - 1) never wraps
//
// Optional feature macro used by the including files: PRPG_HD_STATS_EN.
package prpg_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_AVG  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam int DEF_W     = 8;
    localparam int DEF_CNT_W = 8;

    function automatic int sum_w(input int w, input int cnt_w);
        return $clog2(w + 1) + cnt_w;
    endfunction

endpackage

// File: rtl/prpg_hd_div.sv
// prpg_hd_div -- serial restoring divider, one quotient bit per clock.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : one-cycle request; dividend_i/divisor_i sampled here
//   dividend_i   : DIVIDEND_W-bit unsigned dividend
//   divisor_i    : DIVISOR_W-bit unsigned divisor (never zero when started)
//   done_o       : one-cycle pulse, DIVIDEND_W cycles after start_i
//   quotient_o   : low QUOT_W bits of the quotient, valid from done_o onward
//
// The first quotient bit is resolved on the start edge itself so that
// done_o rises exactly DIVIDEND_W cycles after the request.
module prpg_hd_div #(
    parameter int DIVIDEND_W = 12,
    parameter int DIVISOR_W  = 8,
    parameter int QUOT_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  done_o,
    output logic [QUOT_W-1:0]     quotient_o
);

    localparam int CNT_BITS = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem_q;
    logic [DIVIDEND_W-1:0] quo_q;
    logic [DIVISOR_W-1:0]  dvsr_q;
    logic [CNT_BITS-1:0]   cnt_q;
    logic                  busy_q;
    logic                  done_q;

    // One restoring step: shift the next dividend bit into the remainder,
    // subtract if it fits. The quotient register doubles as the dividend
    // shift register, so quotient bits enter at the bottom.
    function automatic logic [DIVISOR_W+DIVIDEND_W-1:0] div_step(
        input logic [DIVISOR_W-1:0]  rem,
        input logic [DIVIDEND_W-1:0] quo,
        input logic [DIVISOR_W-1:0]  dvsr
    );
        logic [DIVISOR_W:0] sh;
        logic [DIVISOR_W:0] trial;
        sh    = {rem, quo[DIVIDEND_W-1]};
        trial = sh - {1'b0, dvsr};
        // Borrow out of the top bit means the divisor did not fit.
        if (trial[DIVISOR_W])
            return {sh[DIVISOR_W-1:0], quo[DIVIDEND_W-2:0], 1'b0};
        else
            return {trial[DIVISOR_W-1:0], quo[DIVIDEND_W-2:0], 1'b1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                {rem_q, quo_q} <= div_step('0, dividend_i, divisor_i);
                dvsr_q <= divisor_i;
                cnt_q  <= CNT_BITS'(DIVIDEND_W - 1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                {rem_q, quo_q} <= div_step(rem_q, quo_q, dvsr_q);
                cnt_q <= cnt_q - CNT_BITS'(1);
                if (cnt_q == CNT_BITS'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q[QUOT_W-1:0];

endmodule

// File: rtl/prpg_seq_ctrl.sv
// prpg_seq_ctrl -- pseudo-random pattern generator job controller.
//
// A job captures tap/seed/run_len on start, loads the seed, then steps a
// Galois-style LFSR run_len times (stalling while hold is high). Optionally
// it accumulates the Hamming distance between consecutive patterns and
// reports the floor of the mean per-step distance.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : job request, honoured only in IDLE
//   tap          : feedback mask (W-1 bits), captured at start
//   seed         : initial pattern, captured at start
//   run_len      : number of LFSR steps, captured at start
//   hold         : stalls stepping while high
//   busy         : high whenever the FSM is not IDLE
//   done         : one-cycle job-complete pulse
//   pattern      : current LFSR register
//   pattern_vld  : one-cycle pulse after each committed step
//   step_cnt     : steps committed in the current job
//   hd_avg       : floor(mean Hamming distance per step)
//   err_lockup   : seed was all-zero (meaningful while done is high)
//
// Configuration macro: PRPG_HD_STATS_EN
//   defined   : HD accumulator, AVG state and prpg_hd_div are built
//   undefined : no HD logic, hd_avg is 0, RUN goes straight to DONE
module prpg_seq_ctrl
    import prpg_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [W-2:0]           tap,
    input  logic [W-1:0]           seed,
    input  logic [CNT_W-1:0]       run_len,
    input  logic                   hold,
    output logic                   busy,
    output logic                   done,
    output logic [W-1:0]           pattern,
    output logic                   pattern_vld,
    output logic [CNT_W-1:0]       step_cnt,
    output logic [$clog2(W+1)-1:0] hd_avg,
    output logic                   err_lockup
);

    localparam int HD_W = $clog2(W + 1);

    state_e           state_q;
    logic [W-2:0]     tap_q;
    logic [W-1:0]     seed_q;
    logic [CNT_W-1:0] run_len_q;
    logic [W-1:0]     pattern_q;
    logic [W-1:0]     pattern_d;
    logic [CNT_W-1:0] step_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             vld_q;
    logic             err_q;

    // Shift left with the MSB wrapping into bit 0; tap bit W-1-i gates the
    // feedback into bit i, so tap[W-2] feeds bit 1 and tap[0] feeds the MSB.
    function automatic logic [W-1:0] lfsr_next(
        input logic [W-1:0] p,
        input logic [W-2:0] t
    );
        logic [W-1:0] n;
        n[0] = p[W-1];
        for (int i = 1; i < W; i++)
            n[i] = p[i-1] ^ (t[W-1-i] & p[W-1]);
        return n;
    endfunction

    always_comb begin
        pattern_d = lfsr_next(pattern_q, tap_q);
    end

`ifdef PRPG_HD_STATS_EN
    localparam int SUM_W = sum_w(W, CNT_W);

    logic [SUM_W-1:0] hd_sum_q;
    logic [HD_W-1:0]  hd_avg_q;
    logic             div_start;
    logic             div_done;
    logic [HD_W-1:0]  div_quo;

    // The division is launched on the same edge that RUN hands over to AVG.
    assign div_start = (state_q == S_RUN) && (step_cnt_q == run_len_q);

    prpg_hd_div #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .QUOT_W     (HD_W)
    ) u_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (div_start),
        .dividend_i (hd_sum_q),
        .divisor_i  (run_len_q),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tap_q      <= '0;
            seed_q     <= '0;
            run_len_q  <= '0;
            pattern_q  <= '0;
            step_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef PRPG_HD_STATS_EN
            hd_sum_q   <= '0;
            hd_avg_q   <= '0;
`endif
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        tap_q     <= tap;
                        seed_q    <= seed;
                        run_len_q <= run_len;
                        busy_q    <= 1'b1;
                        state_q   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    pattern_q  <= seed_q;
                    step_cnt_q <= '0;
                    err_q      <= (seed_q == '0);
`ifdef PRPG_HD_STATS_EN
                    hd_sum_q   <= '0;
                    hd_avg_q   <= '0;
`endif
                    // An all-zero seed would lock the LFSR; skip the run.
                    if (seed_q == '0 || run_len_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (step_cnt_q == run_len_q) begin
`ifdef PRPG_HD_STATS_EN
                        state_q <= S_AVG;
`else
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
`endif
                    end else if (!hold) begin
                        pattern_q  <= pattern_d;
                        step_cnt_q <= step_cnt_q + CNT_W'(1);
                        vld_q      <= 1'b1;
`ifdef PRPG_HD_STATS_EN
                        hd_sum_q   <= hd_sum_q + SUM_W'($countones(pattern_q ^ pattern_d));
`endif
                    end
                end
`ifdef PRPG_HD_STATS_EN
                S_AVG: begin
                    if (div_done) begin
                        hd_avg_q <= div_quo;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pattern     = pattern_q;
    assign pattern_vld = vld_q;
    assign step_cnt    = step_cnt_q;
    assign err_lockup  = err_q;
`ifdef PRPG_HD_STATS_EN
    assign hd_avg      = hd_avg_q;
`else
    assign hd_avg      = '0;
`endif

endmodule

// File: tb/tb_prpg_seq_ctrl.sv
// tb_prpg_seq_ctrl -- randomized and directed bench for prpg_seq_ctrl.
// Expected values come from a job-level model (integer rotate/xor LFSR,
// integer mean of Hamming distances, closed-form latency).
// Honours PRPG_HD_STATS_EN the same way the design does.
module tb_prpg_seq_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 8;
    localparam int SUM_W = $clog2(W + 1) + CNT_W;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-2:0]     tap;
    logic [W-1:0]     seed;
    logic [CNT_W-1:0] run_len;
    logic             hold;
    logic             busy;
    logic             done;
    logic [W-1:0]     pattern;
    logic             pattern_vld;
    logic [CNT_W-1:0] step_cnt;
    logic [3:0]       hd_avg;
    logic             err_lockup;

    int n_vec;
    int n_err;

    prpg_seq_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .tap         (tap),
        .seed        (seed),
        .run_len     (run_len),
        .hold        (hold),
        .busy        (busy),
        .done        (done),
        .pattern     (pattern),
        .pattern_vld (pattern_vld),
        .step_cnt    (step_cnt),
        .hd_avg      (hd_avg),
        .err_lockup  (err_lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Rotate left by one, then xor the bit-reversed tap mask (aligned to
    // bits 1..W-1) when the bit that wrapped around was a one.
    function automatic int next_pat(input int p, input logic [W-2:0] tp);
        int fb;
        int msb;
        fb = 0;
        for (int i = 1; i < W; i++)
            if (tp[W-1-i]) fb |= (1 << i);
        msb = (p >> (W - 1)) & 1;
        return ((((p << 1) | msb) & 'hFF) ^ (msb != 0 ? fb : 0));
    endfunction

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, "_busy"},    busy,        0);
        check_eq({tag, "_done"},    done,        0);
        check_eq({tag, "_vld"},     pattern_vld, 0);
        check_eq({tag, "_pattern"}, pattern,     0);
        check_eq({tag, "_stepcnt"}, step_cnt,    0);
        check_eq({tag, "_hdavg"},   hd_avg,      0);
        check_eq({tag, "_lockup"},  err_lockup,  0);
    endtask

    task automatic run_job(input logic [W-2:0] tp, input logic [W-1:0] sd,
                           input logic [CNT_W-1:0] len, input int hold_at,
                           input int hold_n, input bit poke_start);
        int exp_pat[$];
        int p;
        int n;
        int hsum;
        int exp_lat;
        int exp_steps;
        int exp_avg;
        int vcount;
        int cyc;
        bit seen_done;

        // Job-level model.
        p = int'(sd);
        hsum = 0;
        exp_steps = (sd == 0) ? 0 : int'(len);
        for (int k = 0; k < exp_steps; k++) begin
            n = next_pat(p, tp);
            hsum += $countones(p ^ n);
            exp_pat.push_back(n);
            p = n;
        end
        if (exp_steps == 0) exp_lat = 1;
`ifdef PRPG_HD_STATS_EN
        else exp_lat = 2 + int'(len) + hold_n + SUM_W;
        exp_avg = (exp_steps == 0) ? 0 : hsum / int'(len);
`else
        else exp_lat = 2 + int'(len) + hold_n;
        exp_avg = 0;
`endif

        @(negedge clk);
        start = 1'b1; tap = tp; seed = sd; run_len = len;
        @(negedge clk);
        // Scramble the job inputs to show they were captured.
        start = 1'b0;
        tap = (W-1)'($urandom); seed = W'($urandom); run_len = CNT_W'($urandom);
        cyc = 0; vcount = 0; seen_done = 1'b0;
        while (!seen_done && cyc < 400) begin
            if (cyc == 0) check_eq("busy_after_start", busy, 1);
            if (pattern_vld) begin
                if (vcount < exp_pat.size())
                    check_eq("step_pattern", pattern, exp_pat[vcount]);
                check_eq("step_count", step_cnt, vcount + 1);
                vcount++;
            end
            if (done) begin
                seen_done = 1'b1;
                check_eq("done_latency", cyc, exp_lat);
                check_eq("done_busy", busy, 1);
                check_eq("vld_pulses", vcount, exp_steps);
                check_eq("final_stepcnt", step_cnt, exp_steps);
                check_eq("final_pattern", pattern, (exp_steps == 0) ? int'(sd) : exp_pat[exp_steps-1]);
                check_eq("hd_avg", hd_avg, exp_avg);
                check_eq("err_lockup", err_lockup, (sd == 0) ? 1 : 0);
            end else begin
                hold = (cyc >= hold_at && cyc < hold_at + hold_n);
                start = poke_start && (cyc == 3);
                if (start) run_len = len + 8'd5;
                @(negedge clk);
                cyc++;
            end
        end
        hold = 1'b0;
        start = 1'b0;
        if (!seen_done) check_eq("done_timeout", 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("post_done", done, 0);
            check_eq("post_busy", busy, 0);
        end
    endtask

    initial begin
        int len;
        int h_at;
        int h_n;
        logic [W-1:0] sd;

        n_vec = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; hold = 1'b0;
        tap = '0; seed = '0; run_len = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed scenarios.
        run_job(7'b0000000, 8'h01, 8'd8, 0, 0, 1'b0);
        run_job(7'b0000000, 8'h00, 8'd5, 0, 0, 1'b0);
        run_job(7'b0000000, 8'h0F, 8'd0, 0, 0, 1'b0);
        run_job(7'b0100101, 8'h0F, 8'd10, 0, 0, 1'b0);
        run_job(7'b0100101, 8'h0F, 8'd10, 4, 3, 1'b0);
        run_job(7'b1011010, 8'hA5, 8'd10, 0, 0, 1'b1);

        // Reset asserted mid-job (inside AVG when statistics are built).
        @(negedge clk);
        start = 1'b1; tap = 7'b0011101; seed = 8'h3C; run_len = 8'd12;
        @(negedge clk);
        start = 1'b0;
`ifdef PRPG_HD_STATS_EN
        repeat (2 + 12 + 3) @(negedge clk);
`else
        repeat (5) @(negedge clk);
`endif
        check_eq("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midjob_reset");
        @(negedge clk);
        check_zero_outputs("held_reset");
        rst_n = 1'b1;
        @(negedge clk);
        run_job(7'b0011101, 8'h3C, 8'd12, 0, 0, 1'b0);

        // Randomized jobs.
        for (int j = 0; j < 12; j++) begin
            len = $urandom_range(0, 20);
            sd = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            if (len > 0) begin
                h_at = $urandom_range(1, len);
                h_n  = $urandom_range(0, 3);
            end else begin
                h_at = 0;
                h_n  = 0;
            end
            run_job(7'($urandom), sd, 8'(len), h_at, h_n, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
